gamma_prog_top: RTL and testbench

GAMMA_PROG_TOP -- requirements
Module: gamma_prog_top

---
 rtl/gamma_prog_top.sv | 150 +++++++++++++++
 tb/tb_gamma_prog_top.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gamma_prog_top.sv
// gamma_prog_top
// Programmable per-channel gamma correction with double-buffered lookup
// tables. Every channel owns two banks of 2^DW x DW entries. Lookups always
// read the active bank. Configuration writes always land in the shadow bank,
// so a table can be rebuilt while video is running. A swap request is held
// pending and takes effect at the next frame start, which is the rising edge
// of in_vsync. At that point the shadow bank becomes active and the tables
// are marked valid. Until the first swap, or while bypass is latched, pixels
// pass through unchanged. All outputs lag their inputs by exactly two cycles.
//
// Ports
//   clk            : sole clock, rising edge
//   reset_n        : asynchronous active-low reset
//   in_vsync/hsync/den, in_data : input video timing and packed pixel
//                    (channel 0 at [DW-1:0])
//   bypass         : identity request, sampled only at frame start
//   cfg_we, cfg_ch, cfg_addr, cfg_wdata : shadow-bank write port
//   cfg_swap_req   : one-cycle pulse requesting a bank swap
//   out_vsync/hsync/den, out_data : delayed timing and corrected pixel
//   swap_pending   : a swap is waiting for the next frame start
//   active_bank    : bank currently used for lookups
module gamma_prog_top #(
    parameter int DW  = 8,
    parameter int CH  = 3,
    parameter int CHW = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_vsync,
    input  logic             in_hsync,
    input  logic             in_den,
    input  logic [CH*DW-1:0] in_data,
    input  logic             bypass,
    input  logic             cfg_we,
    input  logic [CHW-1:0]   cfg_ch,
    input  logic [DW-1:0]    cfg_addr,
    input  logic [DW-1:0]    cfg_wdata,
    input  logic             cfg_swap_req,
    output logic             out_vsync,
    output logic             out_hsync,
    output logic             out_den,
    output logic [CH*DW-1:0] out_data,
    output logic             swap_pending,
    output logic             active_bank
);

    logic             vsync_prev;
    logic             frame_start;
    logic             bypass_q;
    logic             lut_valid;

    logic             d1_vsync;
    logic             d1_hsync;
    logic             d1_den;
    logic             d1_ident;
    logic [CH*DW-1:0] d1_data;
    logic [CH*DW-1:0] lut_rd;

    assign frame_start = in_vsync & ~vsync_prev;

    // Bank control. A swap that is already pending when a frame starts is
    // committed in that cycle. A request that arrives together with that
    // frame start is absorbed, because a swap is already pending. A request
    // that arrives on a frame start with nothing pending only arms the swap,
    // so it takes effect at the following frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_prev   <= 1'b0;
            bypass_q     <= 1'b0;
            lut_valid    <= 1'b0;
            swap_pending <= 1'b0;
            active_bank  <= 1'b0;
        end else begin
            vsync_prev <= in_vsync;
            if (frame_start) begin
                bypass_q <= bypass;
            end
            if (frame_start && swap_pending) begin
                active_bank  <= ~active_bank;
                swap_pending <= 1'b0;
                lut_valid    <= 1'b1;
            end else if (cfg_swap_req) begin
                swap_pending <= 1'b1;
            end
        end
    end

    // Stage 1: delay the timing signals and the raw pixel alongside the table
    // read. The identity decision is taken from the state of this cycle, so it
    // stays aligned with the bank that the read used.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d1_vsync <= 1'b0;
            d1_hsync <= 1'b0;
            d1_den   <= 1'b0;
            d1_ident <= 1'b1;
            d1_data  <= '0;
        end else begin
            d1_vsync <= in_vsync;
            d1_hsync <= in_hsync;
            d1_den   <= in_den;
            d1_ident <= bypass_q | ~lut_valid;
            d1_data  <= in_data;
        end
    end

    // One table per channel. Bank and address are packed into a single index.
    // Writes go to the inverted bank bit and reads use the bank bit as it is,
    // so a write and a lookup can never touch the same entry. The table is
    // left unreset so that it can map onto block RAM.
    for (genvar c = 0; c < CH; c++) begin : g_chan
        logic [DW-1:0] mem [2**(DW+1)];
        logic [DW-1:0] rd_q;
        logic          wr_en;

        assign wr_en = cfg_we && (cfg_ch == CHW'(c));

        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem[{~active_bank, cfg_addr}] <= cfg_wdata;
            end
            rd_q <= mem[{active_bank, in_data[c*DW +: DW]}];
        end

        assign lut_rd[c*DW +: DW] = rd_q;
    end

    // Stage 2: select the corrected or identity pixel, and blank the pixel
    // outside the active display.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_vsync <= 1'b0;
            out_hsync <= 1'b0;
            out_den   <= 1'b0;
            out_data  <= '0;
        end else begin
            out_vsync <= d1_vsync;
            out_hsync <= d1_hsync;
            out_den   <= d1_den;
            if (!d1_den) begin
                out_data <= '0;
            end else if (d1_ident) begin
                out_data <= d1_data;
            end else begin
                out_data <= lut_rd;
            end
        end
    end

endmodule

// File: tb/tb_gamma_prog_top.sv
// tb_gamma_prog_top
// Randomized bench for gamma_prog_top using DW=8 and CH=3. A reference model
// keeps the tables, the bank, pending and bypass state, and a queue of the
// expected outputs. Each output is computed when its pixel is driven and
// compared two cycles later.
module tb_gamma_prog_top;

    localparam int DW    = 8;
    localparam int CH    = 3;
    localparam int CHW   = 2;
    localparam int FRAME = 40;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_vsync = 1'b0;
    logic             in_hsync = 1'b0;
    logic             in_den = 1'b0;
    logic [CH*DW-1:0] in_data = '0;
    logic             bypass = 1'b0;
    logic             cfg_we = 1'b0;
    logic [CHW-1:0]   cfg_ch = '0;
    logic [DW-1:0]    cfg_addr = '0;
    logic [DW-1:0]    cfg_wdata = '0;
    logic             cfg_swap_req = 1'b0;
    logic             out_vsync;
    logic             out_hsync;
    logic             out_den;
    logic [CH*DW-1:0] out_data;
    logic             swap_pending;
    logic             active_bank;

    gamma_prog_top #(.DW(DW), .CH(CH), .CHW(CHW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_vsync     (in_vsync),
        .in_hsync     (in_hsync),
        .in_den       (in_den),
        .in_data      (in_data),
        .bypass       (bypass),
        .cfg_we       (cfg_we),
        .cfg_ch       (cfg_ch),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .cfg_swap_req (cfg_swap_req),
        .out_vsync    (out_vsync),
        .out_hsync    (out_hsync),
        .out_den      (out_den),
        .out_data     (out_data),
        .swap_pending (swap_pending),
        .active_bank  (active_bank)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vs;
        logic        hs;
        logic        de;
        logic [23:0] d;
    } exp_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   pos = 0;
    logic byp_drv = 1'b0;

    logic [7:0] lut_m [CH][2][256];
    bit         m_bank, m_pend, m_valid, m_bypq, m_vsprev;
    exp_t       expq[$];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One cycle. Compare the outputs owed from two cycles ago and the current
    // status, then drive new inputs and advance the model to match the
    // coming clock edge.
    task automatic applyStimulus(input bit we, input int ch, input int addr, input int wdata,
                                 input bit req, input bit force_pix, input logic [23:0] pix);
        exp_t        e;
        logic        vs, hs, de, fs;
        logic [23:0] d;
        logic [7:0]  comp;
        @(negedge clk);
        if (expq.size() == 2) begin
            e = expq.pop_front();
            checkOutput("out_vsync", out_vsync, e.vs);
            checkOutput("out_hsync", out_hsync, e.hs);
            checkOutput("out_den", out_den, e.de);
            checkOutput("out_data", out_data, e.d);
        end
        checkOutput("swap_pending", swap_pending, m_pend);
        checkOutput("active_bank", active_bank, m_bank);

        vs = (pos % FRAME) < 3;
        hs = (pos % 8) == 0;
        de = force_pix ? 1'b1 : ((pos % FRAME) >= 5 && $urandom_range(0, 7) != 0);
        d  = force_pix ? pix : 24'($urandom);
        in_vsync     = vs;
        in_hsync     = hs;
        in_den       = de;
        in_data      = d;
        bypass       = byp_drv;
        cfg_we       = we;
        cfg_ch       = CHW'(ch);
        cfg_addr     = 8'(addr);
        cfg_wdata    = 8'(wdata);
        cfg_swap_req = req;

        e.vs = vs;
        e.hs = hs;
        e.de = de;
        e.d  = '0;
        if (de) begin
            for (int c = 0; c < CH; c++) begin
                comp = d[c*8 +: 8];
                e.d[c*8 +: 8] = (m_bypq || !m_valid) ? comp : lut_m[c][m_bank][comp];
            end
        end
        expq.push_back(e);

        if (we && ch < CH) lut_m[ch][!m_bank][addr] = 8'(wdata);
        fs = vs && !m_vsprev;
        if (fs && m_pend) begin
            m_bank  = !m_bank;
            m_pend  = 1'b0;
            m_valid = 1'b1;
        end else if (req) begin
            m_pend = 1'b1;
        end
        if (fs) m_bypq = byp_drv;
        m_vsprev = vs;
        pos++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, '0);
    endtask

    // mode 0: ch0 inverted, others identity; 1: random; 2: all inverted
    task automatic fillShadow(input int mode);
        int w;
        for (int a = 0; a < 256; a++) begin
            for (int c = 0; c < CH; c++) begin
                case (mode)
                    0:       w = (c == 0) ? 255 - a : a;
                    1:       w = $urandom_range(0, 255);
                    default: w = 255 - a;
                endcase
                applyStimulus(1, c, a, w, 0, 0, '0);
            end
        end
    endtask

    task automatic waitFramePos(input int p);
        for (int i = 0; i < FRAME && (pos % FRAME) != p; i++) idle(1);
    endtask

    task automatic checkPixel(input string tag, input logic [23:0] pix, input logic [23:0] exp);
        applyStimulus(0, 0, 0, 0, 0, 1, pix);
        idle(2);
        checkOutput({tag, "_den"}, out_den, 1'b1);
        checkOutput(tag, out_data, exp);
    endtask

    task automatic resetDut();
        exp_t z;
        @(negedge clk);
        reset_n      = 1'b0;
        in_vsync     = 1'b0;
        in_hsync     = 1'b0;
        in_den       = 1'b0;
        in_data      = '0;
        cfg_we       = 1'b0;
        cfg_swap_req = 1'b0;
        #1;
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_den", out_den, 0);
        checkOutput("rst_out_vsync", out_vsync, 0);
        checkOutput("rst_out_hsync", out_hsync, 0);
        checkOutput("rst_swap_pending", swap_pending, 0);
        checkOutput("rst_active_bank", active_bank, 0);
        @(negedge clk);
        reset_n  = 1'b1;
        m_bank   = 1'b0;
        m_pend   = 1'b0;
        m_valid  = 1'b0;
        m_bypq   = 1'b0;
        m_vsprev = 1'b0;
        z.vs = 1'b0;
        z.hs = 1'b0;
        z.de = 1'b0;
        z.d  = '0;
        expq.delete();
        expq.push_back(z);
        expq.push_back(z);
        pos = 10;
    endtask

    initial begin
        resetDut();

        // Tables not yet valid: identity whatever bypass does
        for (int i = 0; i < 60; i++) begin
            if (i % 20 == 0) byp_drv = 1'($urandom_range(0, 1));
            idle(1);
        end
        checkPixel("ident_before_swap", 24'h1080FF, 24'h1080FF);
        byp_drv = 1'b0;

        // Inverted ch0 table, plus a write to a nonexistent channel
        fillShadow(0);
        applyStimulus(1, 3, 8'h10, 8'h00, 0, 0, '0);
        waitFramePos(15);
        applyStimulus(0, 0, 0, 0, 1, 0, '0);
        idle(1);
        checkOutput("pending_after_req", swap_pending, 1'b1);
        idle(2 * FRAME);
        checkOutput("bank_after_swap", active_bank, 1'b1);
        checkOutput("pending_cleared", swap_pending, 1'b0);
        checkPixel("inv_ch0", 24'hFF8010, 24'hFF80EF);

        // Request coincident with frame start waits a full frame
        fillShadow(1);
        waitFramePos(0);
        applyStimulus(0, 0, 0, 0, 1, 0, '0);
        idle(2);
        checkOutput("no_swap_same_frame", active_bank, 1'b1);
        checkOutput("pending_held", swap_pending, 1'b1);
        idle(FRAME);
        checkOutput("swap_next_frame", active_bank, 1'b0);
        checkOutput("pending_clear2", swap_pending, 1'b0);

        // Bypass raised mid-frame only takes effect at the next frame
        fillShadow(2);
        waitFramePos(20);
        applyStimulus(0, 0, 0, 0, 1, 0, '0);
        idle(2 * FRAME);
        checkOutput("bank_inv_all", active_bank, 1'b1);
        waitFramePos(15);
        byp_drv = 1'b1;
        checkPixel("bypass_mid_frame", 24'h123456, 24'hEDCBA9);
        waitFramePos(10);
        checkPixel("bypass_next_frame", 24'h123456, 24'h123456);
        byp_drv = 1'b0;

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if (i % 100 == 0) byp_drv = 1'($urandom_range(0, 1));
            applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 255),
                          $urandom_range(0, 255), $urandom_range(0, 99) < 3, 0, '0);
        end
        byp_drv = 1'b0;

        // Reset mid-frame with a swap pending
        waitFramePos(20);
        applyStimulus(0, 0, 0, 0, 1, 0, '0);
        idle(3);
        checkOutput("pending_before_reset", swap_pending, 1'b1);
        resetDut();
        idle(1);
        checkOutput("pending_after_reset", swap_pending, 1'b0);
        checkOutput("bank_after_reset", active_bank, 1'b0);
        checkPixel("ident_after_reset", 24'hA5C33C, 24'hA5C33C);
        idle(80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
